alu_ex_stage: RTL and testbench

//  Registered execute stage of the MIPS datapath; sits directly downstream of ALU control.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_core.sv | 53 +++++
 rtl/alu_ex_stage.sv | 99 +++++++++
 tb/tb_alu_ex_stage.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit ALU control codes and the R-type function codes
// that the ALU control block decodes into them.
package alu_pkg;

    localparam int ALU_DW = 32;
    localparam int ALU_RW = 5;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_ADDU = 4'b1000,
        ALU_SUBU = 4'b1001,
        ALU_XOR  = 4'b1010,
        ALU_SLTU = 4'b1011,
        ALU_NOR  = 4'b1100,
        ALU_SRA  = 4'b1101,
        ALU_LUI  = 4'b1110
    } alu_op_t;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2a;
    localparam logic [5:0] FUNCT_SLTU = 6'h2b;

endpackage

// File: rtl/alu_core.sv
// Purely combinational MIPS ALU: (op, a, b, shamt) -> (result, signed overflow).
module alu_core
    import alu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [3:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [4:0]    i_shamt,
    output logic [DW-1:0] o_result,
    output logic          o_ovf
);

    logic [DW-1:0] w_sum;
    logic [DW-1:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        o_result = '0;
        o_ovf    = 1'b0;
        case (alu_op_t'(i_op))
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_ADD: begin
                o_result = w_sum;
                o_ovf    = (i_a[DW-1] == i_b[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
            end
            ALU_SUB: begin
                o_result = w_diff;
                o_ovf    = (i_a[DW-1] != i_b[DW-1]) && (w_diff[DW-1] != i_a[DW-1]);
            end
            ALU_ADDU: o_result = w_sum;
            ALU_SUBU: o_result = w_diff;
            ALU_SLT:  o_result = {{(DW-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {{(DW-1){1'b0}}, (i_a < i_b)};
            // Shifts act on operand B (rt), matching MIPS sll/srl/sra.
            ALU_SLL:  o_result = i_b << i_shamt;
            ALU_SRL:  o_result = i_b >> i_shamt;
            ALU_SRA:  o_result = $signed(i_b) >>> i_shamt;
            ALU_LUI:  o_result = {i_b[15:0], {(DW-16){1'b0}}};
            default: begin
                o_result = '0;
                o_ovf    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Registered MIPS execute stage: one-entry valid/ready output register around alu_core.
// Optional overflow trap (out_ovf, out_rd suppression) enabled by defining ALU_OVF_TRAP_EN.
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_alu_ctrl,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [4:0]    in_shamt,
    input  logic [RW-1:0] in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_zero,
    output logic          out_ovf
);

    // Handshake: a transfer happens on an edge where valid && ready. The
    // producer holds its payload stable while valid is high and ready is low.
    logic          r_valid;
    logic [DW-1:0] r_result;
    logic [RW-1:0] r_rd;
    logic [DW-1:0] w_result;
    logic          w_ovf;
    logic          w_accept;

    alu_core #(.DW(DW)) u_alu_core (
        .i_op     (in_alu_ctrl),
        .i_a      (in_a),
        .i_b      (in_b),
        .i_shamt  (in_shamt),
        .o_result (w_result),
        .o_ovf    (w_ovf)
    );

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

`ifdef ALU_OVF_TRAP_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
            r_ovf    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_result;
            // A trapping op must not write the register file.
            r_rd     <= w_ovf ? '0 : in_rd;
            r_ovf    <= w_ovf;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_ovf = r_ovf;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = w_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_result;
            r_rd     <= in_rd;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_ovf = 1'b0;
`endif

    assign out_valid  = r_valid;
    assign out_result = r_result;
    assign out_rd     = r_rd;
    assign out_zero   = (r_result == '0);

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: scoreboard queue fed at accept, drained at output transfer.
// Expected overflow/rd behaviour follows ALU_OVF_TRAP_EN when defined.
module tb_alu_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_alu_ctrl = 4'h0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [4:0]    in_shamt = '0;
    logic [RW-1:0] in_rd = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_result;
    logic [RW-1:0] out_rd;
    logic          out_zero;
    logic          out_ovf;

    int  n_cmp = 0;
    int  n_err = 0;
    int  pop_cnt = 0;
    bit  last_accept = 1'b0;
    bit  rand_bp = 1'b0;

    // Each entry is {ovf, rd, result}.
    logic [37:0] exp_q[$];

    alu_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu_ctrl (in_alu_ctrl),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_shamt    (in_shamt),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_zero    (out_zero),
        .out_ovf     (out_ovf)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [37:0] got, input logic [37:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [37:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh,
                                          input logic [4:0] rd);
        logic [31:0]        r;
        logic               v;
        logic signed [32:0] s;
        r = '0;
        v = 1'b0;
        s = '0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin
                s = $signed({a[31], a}) + $signed({b[31], b});
                r = s[31:0];
                v = s[32] ^ s[31];
            end
            4'h3: r = b << sh;
            4'h4: r = b >> sh;
            4'h6: begin
                s = $signed({a[31], a}) - $signed({b[31], b});
                r = s[31:0];
                v = s[32] ^ s[31];
            end
            4'h7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h8: r = a + b;
            4'h9: r = a - b;
            4'ha: r = a ^ b;
            4'hb: r = (a < b) ? 32'd1 : 32'd0;
            4'hc: r = ~(a | b);
            4'hd: r = (b >> sh) | (b[31] ? ~(32'hffff_ffff >> sh) : 32'd0);
            4'he: r = {b[15:0], 16'h0000};
            default: r = '0;
        endcase
`ifdef ALU_OVF_TRAP_EN
        return {v, (v ? 5'd0 : rd), r};
`else
        return {1'b0, rd, r};
`endif
    endfunction

    // ---------------- one cycle: monitor/scoreboard, then advance ----------------
    // Called at a falling edge; samples 1 time unit later, before the next rising edge.
    task automatic cycle();
        logic [37:0] item;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 38'(exp_q.size()), 38'd1);
            end else begin
                item = exp_q.pop_front();
                check("out_data", {out_ovf, out_rd, out_result}, item);
                check("out_zero", 38'(out_zero), 38'(item[31:0] == 32'd0));
            end
            pop_cnt++;
        end else if (flush && out_valid) begin
            void'(exp_q.pop_front());
        end
        last_accept = in_valid && in_ready;
        if (last_accept && !flush)
            exp_q.push_back(model(in_alu_ctrl, in_a, in_b, in_shamt, in_rd));
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [4:0] rd);
        in_valid    = 1'b1;
        in_alu_ctrl = op;
        in_a        = a;
        in_b        = b;
        in_shamt    = sh;
        in_rd       = rd;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_accept) return;
        end
        check("send_timeout", 38'(last_accept), 38'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Send with the output stalled, check the held result directly, then drain it.
    task automatic send_hold_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh,
                                   input logic [4:0] rd, input logic [31:0] exp_r);
        out_ready = 1'b0;
        send(op, a, b, sh, rd);
        in_valid = 1'b0;
        check(tag, 38'(out_result), 38'(exp_r));
        out_ready = 1'b1;
        cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        logic [31:0] ra, rb;
        logic [3:0]  rop;

        repeat (3) @(negedge clk);
        #1;
        check("reset_valid", 38'(out_valid), 38'd0);
        check("reset_result", 38'(out_result), 38'd0);
        check("reset_rd", 38'(out_rd), 38'd0);
        check("reset_zero", 38'(out_zero), 38'd1);
        check("reset_ovf", 38'(out_ovf), 38'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 38'(in_ready), 38'd1);
        @(negedge clk);

        // Back-to-back stream: four results on four consecutive cycles.
        out_ready = 1'b1;
        p0 = pop_cnt;
        send(4'h2, 32'd5, 32'd7, 5'd0, 5'd1);
        send(4'h6, 32'd3, 32'd5, 5'd0, 5'd2);
        send(4'h7, 32'hffff_ffff, 32'd1, 5'd0, 5'd3);
        send(4'hb, 32'hffff_ffff, 32'd1, 5'd0, 5'd4);
        idle(1);
        check("stream_pops", 38'(pop_cnt - p0), 38'd4);
        send_hold_check("add_const", 4'h2, 32'd5, 32'd7, 5'd0, 5'd1, 32'd12);
        send_hold_check("sub_const", 4'h6, 32'd3, 32'd5, 5'd0, 5'd2, 32'hffff_fffe);

        // Shifts, LUI and logic ops.
        send_hold_check("sra_const", 4'hd, 32'h0, 32'h8000_0000, 5'd4, 5'd10, 32'hf800_0000);
        send_hold_check("srl_const", 4'h4, 32'h0, 32'h8000_0000, 5'd4, 5'd11, 32'h0800_0000);
        send_hold_check("lui_const", 4'he, 32'h0, 32'h0000_1234, 5'd0, 5'd12, 32'h1234_0000);
        send(4'h3, 32'h0, 32'h0000_0003, 5'd31, 5'd13);
        send(4'h0, 32'hf0f0_ff00, 32'h0ff0_f0f0, 5'd0, 5'd14);
        send(4'h1, 32'hf0f0_0000, 32'h0000_0f0f, 5'd0, 5'd15);
        send(4'ha, 32'haaaa_5555, 32'hffff_0000, 5'd0, 5'd16);
        send(4'hc, 32'h0000_0000, 32'h0000_0000, 5'd0, 5'd17);
        send(4'h5, 32'h1234_5678, 32'h7fff_ffff, 5'd3, 5'd18);
        send(4'hf, 32'h7fff_ffff, 32'd1, 5'd3, 5'd19);
        idle(2);

        // Backpressure: stalled output blocks the next op for three cycles.
        out_ready = 1'b0;
        send(4'h2, 32'd10, 32'd20, 5'd0, 5'd5);
        in_valid = 1'b1;
        in_alu_ctrl = 4'h6;
        in_a = 32'd100;
        in_b = 32'd1;
        in_rd = 5'd6;
        p0 = pop_cnt;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_in_ready", 38'(in_ready), 38'd0);
            check("bp_hold", 38'({out_valid, out_rd, out_result}), {1'b0, 1'b1, 5'd5, 32'd30});
        end
        out_ready = 1'b1;
        cycle();
        check("bp_accept", 38'(last_accept), 38'd1);
        idle(1);
        check("bp_pops", 38'(pop_cnt - p0), 38'd2);

        // Flush on the same cycle as an accept: that op must never appear.
        send(4'h2, 32'd1, 32'd1, 5'd0, 5'd7);
        flush = 1'b1;
        send(4'ha, 32'hdead_beef, 32'h1, 5'd0, 5'd8);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_valid", 38'(out_valid), 38'd0);
        @(negedge clk);
        idle(1);

        // Flush while a result is stalled kills it.
        out_ready = 1'b0;
        send(4'h1, 32'd3, 32'd4, 5'd0, 5'd20);
        in_valid = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        check("flush_held_valid", 38'(out_valid), 38'd0);
        @(negedge clk);
        out_ready = 1'b1;
        idle(1);

        // Signed overflow vs. unsigned add.
        out_ready = 1'b0;
        send(4'h2, 32'h7fff_ffff, 32'd1, 5'd0, 5'd9);
        in_valid = 1'b0;
        check("ovf_result", 38'(out_result), 38'h8000_0000);
`ifdef ALU_OVF_TRAP_EN
        check("ovf_flag", 38'(out_ovf), 38'd1);
        check("ovf_rd", 38'(out_rd), 38'd0);
`else
        check("ovf_flag", 38'(out_ovf), 38'd0);
        check("ovf_rd", 38'(out_rd), 38'd9);
`endif
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        send(4'h8, 32'h7fff_ffff, 32'd1, 5'd0, 5'd9);
        in_valid = 1'b0;
        check("addu_ovf", 38'(out_ovf), 38'd0);
        check("addu_rd", 38'(out_rd), 38'd9);
        out_ready = 1'b1;
        cycle();
        send(4'h6, 32'h8000_0000, 32'd1, 5'd0, 5'd21);
        send(4'h9, 32'h8000_0000, 32'd1, 5'd0, 5'd22);
        send(4'h6, 32'h7fff_ffff, 32'hffff_ffff, 5'd0, 5'd23);
        idle(1);

        // Random ops with random downstream stalls.
        rand_bp = 1'b1;
        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom();
            rb = $urandom();
            if ($urandom_range(0, 3) == 0) ra = {ra[31], 31'h7fff_ffff};
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 2));
            send(rop, ra, rb, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        idle(3);

        // Asynchronous reset while a result is live.
        out_ready = 1'b0;
        send(4'h2, 32'd2, 32'd3, 5'd0, 5'd24);
        in_valid = 1'b0;
        check("mid_pre_valid", 38'(out_valid), 38'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 38'(out_valid), 38'd0);
        check("mid_rst_result", 38'(out_result), 38'd0);
        check("mid_rst_zero", 38'(out_zero), 38'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send(4'ha, 32'h0f, 32'hf0, 5'd0, 5'd25);
        idle(2);

        check("sb_drain", 38'(exp_q.size()), 38'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
